// File: rtl/fetch_pkg.sv
// Shared fetch types: the NOP encoding and the queue entry layout.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/imem_sync.sv
// Instruction memory: one write port, one synchronous read port.
// A read and a write to the same word in one cycle returns the old data.
module imem_sync #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk_i,
  input  logic                           we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr_i,
  input  logic [31:0]                    wdata_i,
  input  logic                           re_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr_i,
  output logic [31:0]                    rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Write and registered read share one edge; the read samples pre-write contents.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: sequential PC, synchronous imem read,
// small FIFO of {pc, instr, fault} toward the decoder, redirect flush.
// Optional: define FETCH_FAULT_CHECK_EN to flag misaligned / out-of-range
// fetches (entry gets fault=1 and a NOP); otherwise addresses alias.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          QUEUE_DEPTH = 2,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           redirect_valid,
  input  logic [31:0]                    redirect_pc,
  input  logic                           imem_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] imem_waddr,
  input  logic [31:0]                    imem_wdata,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [31:0]                    out_instr,
  output logic [31:0]                    out_pc,
  output logic                           out_fault
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int QW = $clog2(QUEUE_DEPTH);

  logic [31:0]  fpc_q, fpc_d;
  logic         ifl_q;
  logic [31:0]  ifl_pc_q;
  logic         ifl_fault_q;
  logic [31:0]  rdata;

  fetch_entry_t q_mem [QUEUE_DEPTH];
  logic [QW-1:0] head_q, tail_q;
  logic [QW:0]   cnt_q;

  logic          issue, push, pop, fetch_fault;
  logic [QW+1:0] occ;
  fetch_entry_t  push_entry, head;

  imem_sync #(.DEPTH_WORDS(DEPTH_WORDS)) u_imem (
    .clk_i   (clk),
    .we_i    (imem_we),
    .waddr_i (imem_waddr),
    .wdata_i (imem_wdata),
    .re_i    (issue),
    .raddr_i (fpc_q[2 +: AW]),
    .rdata_o (rdata)
  );

  // Issue/transfer control. Occupancy discounts this cycle's pop so a
  // drained queue keeps one read in flight per cycle (no bubble at depth 2).
  always_comb begin
    out_valid = (cnt_q != '0) && !redirect_valid;
    pop       = out_valid && out_ready;
    push      = ifl_q && !redirect_valid;
    occ       = (QW+2)'(cnt_q) + (QW+2)'(ifl_q) - (QW+2)'(pop);
    issue     = !redirect_valid && (occ < (QW+2)'(QUEUE_DEPTH));
    fpc_d     = fpc_q;
    if (redirect_valid) fpc_d = redirect_pc;
    else if (issue)     fpc_d = fpc_q + 32'd4;
`ifdef FETCH_FAULT_CHECK_EN
    fetch_fault = (fpc_q[1:0] != 2'b00) || (fpc_q[31:2] >= 30'(DEPTH_WORDS));
`else
    fetch_fault = 1'b0;
`endif
    push_entry.pc    = ifl_pc_q;
    push_entry.fault = ifl_fault_q;
    push_entry.instr = ifl_fault_q ? NOP_INSTR : rdata;
    head      = q_mem[head_q];
    out_pc    = head.pc;
    out_instr = head.instr;
    out_fault = head.fault;
  end

  // Fetch PC and the single in-flight read tag; redirect discards the tag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fpc_q       <= RESET_PC;
      ifl_q       <= 1'b0;
      ifl_pc_q    <= '0;
      ifl_fault_q <= 1'b0;
    end else begin
      fpc_q <= fpc_d;
      ifl_q <= issue;
      if (issue) begin
        ifl_pc_q    <= fpc_q;
        ifl_fault_q <= fetch_fault;
      end
    end
  end

  // Output FIFO; storage is cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) q_mem[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else if (redirect_valid) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        q_mem[tail_q] <= push_entry;
        tail_q        <= tail_q + 1'b1;
      end
      if (pop) head_q <= head_q + 1'b1;
      cnt_q <= cnt_q + (QW+1)'(push) - (QW+1)'(pop);
    end
  end

endmodule
